m68k_bus_cycle_ctrl: RTL

Bus-cycle terminator for the 68000 side of the board FPGA.
- Watches synchronized /AS and FC.
- Decodes the address into FLASH / SRAM / IO / unmapped regions and drives the matching chip selects.
- Inserts programmable wait states, then ends the cycle with /DTACK, /VPA (autovectored IACK) or /BERR (watchdog).
- The top-level controller instantiates it as the sole owner of dtack_n, vpa_n and berr_n.

---
 rtl/m68k_bus_pkg.sv | 46 ++++
 rtl/m68k_bus_cycle_ctrl_sync2.sv | 25 ++
 rtl/m68k_bus_cycle_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - shared types and decode constants for the 68000 bus-cycle terminator
package m68k_bus_pkg;

  // Address region selected for the current bus cycle
  typedef enum logic [2:0] {
    REG_NONE,
    REG_FLASH,
    REG_SRAM,
    REG_IO,
    REG_IACK
  } region_t;

  // Bus-cycle FSM states
  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    ACK,
    TERM
  } state_t;

  // A[23:20] values that select each region
  localparam logic [3:0] FLASH_BASE = 4'h0;
  localparam logic [3:0] SRAM_BASE  = 4'h1;
  localparam logic [3:0] IO_BASE    = 4'hF;

  // Function code of an interrupt-acknowledge cycle
  localparam logic [2:0] FC_IACK = 3'b111;

  // IACK wins over any address; otherwise the top nibble picks the region
  function automatic region_t decode_region(input logic [3:0] nib, input logic [2:0] fc);
    region_t r;
    if (fc == FC_IACK) begin
      r = REG_IACK;
    end else begin
      case (nib)
        FLASH_BASE: r = REG_FLASH;
        SRAM_BASE:  r = REG_SRAM;
        IO_BASE:    r = REG_IO;
        default:    r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/m68k_bus_cycle_ctrl_sync2.sv
// rtl/m68k_bus_cycle_ctrl_sync2.sv - generic two-flop synchronizer with a parameterised reset value
module sync2 #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second gives a clean level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/m68k_bus_cycle_ctrl.sv
// rtl/m68k_bus_cycle_ctrl.sv - 68000 bus-cycle terminator: decode, chip selects, wait states, DTACK/VPA/BERR
module m68k_bus_cycle_ctrl
  import m68k_bus_pkg::*;
#(
  parameter int FLASH_WAIT   = 3,
  parameter int SRAM_WAIT    = 1,
  parameter int IO_WAIT      = 2,
  parameter int BERR_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:1] cpu_addr,
  input  logic [2:0]  cpu_fc,
  input  logic        as_n,
  input  logic        io_ready,
  output logic        dtack_n,
  output logic        vpa_n,
  output logic        berr_n,
  output logic        cs_flash_n,
  output logic        cs_sram_n,
  output logic        cs_io_n,
  output logic        cycle_active
);

  logic             as_s;
  state_t           state, state_d;
  region_t          region_q, region_d;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic [CNT_W-1:0] wd_cnt, wd_cnt_d;
  logic             wait_done;
  logic             cs_live;
  logic             dtack_d, vpa_d, berr_d;
  logic             cs_flash_d, cs_sram_d, cs_io_d, active_d;

  // Low address bits only matter to the selected device, not to the region decode
  logic addr_unused;
  assign addr_unused = ^cpu_addr[19:1];

  // /AS comes straight from the CPU pins and is asynchronous to clk
  sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_as_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (as_n),
    .q     (as_s)
  );

  // Programmed wait states for each decoded region
  function automatic logic [CNT_W-1:0] region_wait(input region_t r);
    logic [CNT_W-1:0] w;
    case (r)
      REG_FLASH: w = CNT_W'(FLASH_WAIT);
      REG_SRAM:  w = CNT_W'(SRAM_WAIT);
      REG_IO:    w = CNT_W'(IO_WAIT);
      default:   w = '0;
    endcase
    return w;
  endfunction

  // FSM state, latched region and the two counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      region_q <= REG_NONE;
      wait_cnt <= '0;
      wd_cnt   <= '0;
    end else begin
      state    <= state_d;
      region_q <= region_d;
      wait_cnt <= wait_cnt_d;
      wd_cnt   <= wd_cnt_d;
    end
  end

  // Next-state, counter and registered-output decisions for the bus cycle
  always_comb begin
    state_d    = state;
    region_d   = region_q;
    wait_cnt_d = wait_cnt;
    wd_cnt_d   = wd_cnt;
    wait_done  = 1'b0;
    dtack_d    = 1'b1;
    vpa_d      = 1'b1;
    berr_d     = 1'b1;

    case (state)
      IDLE: begin
        wait_cnt_d = '0;
        wd_cnt_d   = '0;
        if (!as_s) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        // Address and FC are only looked at here; the latched region governs the rest
        region_d = decode_region(cpu_addr[23:20], cpu_fc);
        // Watchdog starts from zero in DECODE and counts this cycle
        wd_cnt_d = CNT_W'(1);
        if (as_s) begin
          state_d = TERM;
        end else if (region_d == REG_IACK) begin
          // Autovector gets one settle cycle so VPA lands on the second edge
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end else if (region_d == REG_NONE) begin
          // Nothing answers here; the counter is parked and only BERR can finish
          state_d    = WAIT;
          wait_cnt_d = '0;
        end else if (region_wait(region_d) == '0) begin
          state_d = ACK;
          dtack_d = 1'b0;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = region_wait(region_d);
        end
      end

      WAIT: begin
        wd_cnt_d = (wd_cnt == '1) ? wd_cnt : wd_cnt + CNT_W'(1);
        if (region_q != REG_NONE && wait_cnt != '0) begin
          wait_cnt_d = wait_cnt - CNT_W'(1);
        end
        case (region_q)
          REG_NONE: wait_done = 1'b0;
          REG_IO:   wait_done = (wait_cnt <= CNT_W'(1)) && io_ready;
          default:  wait_done = (wait_cnt == CNT_W'(1));
        endcase
        // Abort beats watchdog, watchdog beats a normal acknowledge
        if (as_s) begin
          state_d = TERM;
        end else if (wd_cnt == CNT_W'(BERR_TIMEOUT)) begin
          state_d = ACK;
          berr_d  = 1'b0;
        end else if (wait_done) begin
          state_d = ACK;
          if (region_q == REG_IACK) begin
            vpa_d = 1'b0;
          end else begin
            dtack_d = 1'b0;
          end
        end
      end

      ACK: begin
        dtack_d = dtack_n;
        vpa_d   = vpa_n;
        berr_d  = berr_n;
        if (as_s) begin
          state_d = TERM;
          dtack_d = 1'b1;
          vpa_d   = 1'b1;
          berr_d  = 1'b1;
        end
      end

      TERM: begin
        state_d  = IDLE;
        region_d = REG_NONE;
      end

      default: begin
        state_d  = IDLE;
        region_d = REG_NONE;
      end
    endcase

    // Chip selects follow the region for as long as the cycle is past DECODE
    cs_live    = (state_d == WAIT) || (state_d == ACK);
    cs_flash_d = !(cs_live && region_d == REG_FLASH);
    cs_sram_d  = !(cs_live && region_d == REG_SRAM);
    cs_io_d    = !(cs_live && region_d == REG_IO);
    active_d   = (state_d == DECODE) || cs_live;
  end

  // Glitch-free registered bus outputs, released at once by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtack_n      <= 1'b1;
      vpa_n        <= 1'b1;
      berr_n       <= 1'b1;
      cs_flash_n   <= 1'b1;
      cs_sram_n    <= 1'b1;
      cs_io_n      <= 1'b1;
      cycle_active <= 1'b0;
    end else begin
      dtack_n      <= dtack_d;
      vpa_n        <= vpa_d;
      berr_n       <= berr_d;
      cs_flash_n   <= cs_flash_d;
      cs_sram_n    <= cs_sram_d;
      cs_io_n      <= cs_io_d;
      cycle_active <= active_d;
    end
  end

endmodule
